// File: rtl/iomem_gpio_bank.sv
// -----------------------------------------------------------------------------
// iomem_gpio_bank
//
// Memory-mapped GPIO bank for the PicoSoC iomem bus. It provides WIDTH
// channels. Each channel has an output, an output enable, a pull-up, a
// pull-down and a synchronised input. Rising edges of the (optionally
// debounced) input are latched per channel into IRQ_STATUS, and the enabled
// status bits are ORed into one registered irq line.
//
// Register map (offset = iomem_addr[7:0]; bits 23:8 are ignored, so the map
// aliases):
//   0x00 DATA_OUT    rw
//   0x04 OE          rw   (1 = drive)
//   0x08 DATA_IN     ro   (debounced input)
//   0x0C PULLUP      rw
//   0x10 PULLDOWN    rw
//   0x14 IRQ_EN      rw
//   0x18 IRQ_STATUS  write-1-to-clear
// Other offsets complete with rdata=0 and ignore writes.
//
// Optional feature macro:
//   GPIO_DEBOUNCE_EN  adds a per-channel debounce filter. A new input level is
//                     accepted only after it has stayed stable for
//                     DEBOUNCE_CYC cycles.
//
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   iomem_valid      bus request
//   iomem_ready      one-cycle completion pulse
//   iomem_wstrb[3:0] byte write strobes (0 = read)
//   iomem_addr[31:0] byte address; [31:24] selects this bank
//   iomem_wdata      write data
//   iomem_rdata      read data, valid while iomem_ready=1
//   gpio_in          asynchronous pad inputs
//   gpio_out         DATA_OUT register
//   gpio_oe          OE register
//   gpio_pullup      PULLUP register
//   gpio_pulldown    PULLDOWN register
//   irq              |(IRQ_STATUS & IRQ_EN), registered
// -----------------------------------------------------------------------------
module iomem_gpio_bank #(
  parameter int         WIDTH        = 8,
  parameter logic [7:0] BASE_ADDR    = 8'h07,
  parameter int         SYNC_STAGES  = 2,
  parameter int         DEBOUNCE_CYC = 1000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             iomem_valid,
  output logic             iomem_ready,
  input  logic [3:0]       iomem_wstrb,
  input  logic [31:0]      iomem_addr,
  input  logic [31:0]      iomem_wdata,
  output logic [31:0]      iomem_rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic [WIDTH-1:0] gpio_pullup,
  output logic [WIDTH-1:0] gpio_pulldown,
  output logic             irq
);

  localparam logic [7:0] OFF_DATA_OUT   = 8'h00;
  localparam logic [7:0] OFF_OE         = 8'h04;
  localparam logic [7:0] OFF_DATA_IN    = 8'h08;
  localparam logic [7:0] OFF_PULLUP     = 8'h0C;
  localparam logic [7:0] OFF_PULLDOWN   = 8'h10;
  localparam logic [7:0] OFF_IRQ_EN     = 8'h14;
  localparam logic [7:0] OFF_IRQ_STATUS = 8'h18;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic             sel;
  logic             wr_en;
  logic [7:0]       off;
  logic [31:0]      lane_mask;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] wval;

  // The !iomem_ready term keeps a request that is still held high after
  // completion from being taken a second time.
  assign sel       = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE_ADDR);
  assign wr_en     = sel && (iomem_wstrb != 4'b0000);
  assign off       = iomem_addr[7:0];
  assign lane_mask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                      {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
  assign wmask     = lane_mask[WIDTH-1:0];
  assign wval      = iomem_wdata[WIDTH-1:0];

  // ---------------------------------------------------------------------------
  // Input path: synchroniser -> (debounce) -> edge detect
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  sync;
  logic [WIDTH-1:0]                  deb;
  logic [WIDTH-1:0]                  deb_q;
  logic [WIDTH-1:0]                  rise;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic [WIDTH-1:0][CNT_W-1:0] deb_cnt_q;
  logic [WIDTH-1:0]            deb_r;

  // The counter only runs while the synchronised level differs from the
  // accepted one. A glitch that returns before the terminal count clears it,
  // so the counter never has to wrap.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      deb_cnt_q <= '0;
      deb_r     <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync[i] == deb_r[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == CNT_W'(DEBOUNCE_CYC - 1)) begin
          deb_r[i]     <= sync[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign deb = deb_r;
`else
  assign deb = sync;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      deb_q <= '0;
    end else begin
      deb_q <= deb;
    end
  end

  assign rise = deb & ~deb_q;

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] data_out_q;
  logic [WIDTH-1:0] oe_q;
  logic [WIDTH-1:0] pullup_q;
  logic [WIDTH-1:0] pulldown_q;
  logic [WIDTH-1:0] irq_en_q;
  logic [WIDTH-1:0] irq_status_q;
  logic [WIDTH-1:0] irq_clr;

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old_v,
                                             input logic [WIDTH-1:0] new_v,
                                             input logic [WIDTH-1:0] mask);
    merge = (old_v & ~mask) | (new_v & mask);
  endfunction

  assign irq_clr = (wr_en && off == OFF_IRQ_STATUS) ? (wval & wmask) : '0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_out_q <= '0;
      oe_q       <= '0;
      pullup_q   <= '0;
      pulldown_q <= '0;
      irq_en_q   <= '0;
    end else if (wr_en) begin
      case (off)
        OFF_DATA_OUT: data_out_q <= merge(data_out_q, wval, wmask);
        OFF_OE:       oe_q       <= merge(oe_q,       wval, wmask);
        OFF_PULLUP:   pullup_q   <= merge(pullup_q,   wval, wmask);
        OFF_PULLDOWN: pulldown_q <= merge(pulldown_q, wval, wmask);
        OFF_IRQ_EN:   irq_en_q   <= merge(irq_en_q,   wval, wmask);
        default: ;
      endcase
    end
  end

  // A new edge in the same cycle as a clear of that bit must not be lost,
  // so the set term is ORed in after the clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      irq_status_q <= '0;
    end else begin
      irq_status_q <= (irq_status_q & ~irq_clr) | rise;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      irq <= 1'b0;
    end else begin
      irq <= |(irq_status_q & irq_en_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Read path and handshake
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] rd_val;

  always_comb begin
    rd_val = '0;
    case (off)
      OFF_DATA_OUT:   rd_val = data_out_q;
      OFF_OE:         rd_val = oe_q;
      OFF_DATA_IN:    rd_val = deb;
      OFF_PULLUP:     rd_val = pullup_q;
      OFF_PULLDOWN:   rd_val = pulldown_q;
      OFF_IRQ_EN:     rd_val = irq_en_q;
      OFF_IRQ_STATUS: rd_val = irq_status_q;
      default:        rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
    end else begin
      iomem_ready <= sel;
      if (sel) begin
        iomem_rdata <= 32'(rd_val);
      end
    end
  end

  assign gpio_out      = data_out_q;
  assign gpio_oe       = oe_q;
  assign gpio_pullup   = pullup_q;
  assign gpio_pulldown = pulldown_q;

  // Address bits 23:8 are deliberately ignored, and so are data bits above
  // WIDTH.
  logic unused_inputs;
  assign unused_inputs = ^{iomem_addr[23:8], iomem_wdata, DEBOUNCE_CYC[0]};

endmodule

// File: tb/tb_iomem_gpio_bank.sv
module tb_iomem_gpio_bank;

  localparam int WIDTH       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int DEB_CYC     = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam int DB = DEB_CYC;
`else
  localparam int DB = 0;
`endif

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             iomem_valid = 1'b0;
  logic             iomem_ready;
  logic [3:0]       iomem_wstrb = 4'h0;
  logic [31:0]      iomem_addr = 32'h0;
  logic [31:0]      iomem_wdata = 32'h0;
  logic [31:0]      iomem_rdata;
  logic [WIDTH-1:0] gpio_in = '0;
  logic [WIDTH-1:0] gpio_out;
  logic [WIDTH-1:0] gpio_oe;
  logic [WIDTH-1:0] gpio_pullup;
  logic [WIDTH-1:0] gpio_pulldown;
  logic             irq;

  iomem_gpio_bank #(
    .WIDTH(WIDTH), .BASE_ADDR(8'h07), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYC(DEB_CYC)
  ) dut (
    .clk(clk), .resetn(resetn),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe),
    .gpio_pullup(gpio_pullup), .gpio_pulldown(gpio_pulldown), .irq(irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus transfer, issued just after a rising edge; ready is expected on
  // the very next edge.
  task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                     output logic [31:0] rd);
    int n;
    @(posedge clk); #1;
    iomem_valid = 1'b1; iomem_addr = a; iomem_wstrb = s; iomem_wdata = d;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!iomem_ready && n < 10);
    rd = iomem_rdata;
    iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    chk("bus_latency", 32'(n), 32'd1);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    bus(a, 4'h0, 32'h0, r);
    chk(name, r, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] r;
    bus(a, s, d, r);
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] r;
    int          nsel_hits;

    // wstrb==0 rows are reads compared against exp; others are writes.
    vecs.push_back('{"rst_data_out", 32'h0700_0000, 4'h0, 32'h0, 32'h0});
    vecs.push_back('{"rst_oe",       32'h0700_0004, 4'h0, 32'h0, 32'h0});
    vecs.push_back('{"rst_data_in",  32'h0700_0008, 4'h0, 32'h0, 32'h0});
    vecs.push_back('{"rst_pullup",   32'h0700_000C, 4'h0, 32'h0, 32'h0});
    vecs.push_back('{"rst_pulldown", 32'h0700_0010, 4'h0, 32'h0, 32'h0});
    vecs.push_back('{"rst_irq_en",   32'h0700_0014, 4'h0, 32'h0, 32'h0});
    vecs.push_back('{"rst_status",   32'h0700_0018, 4'h0, 32'h0, 32'h0});
    vecs.push_back('{"w_oe",         32'h0700_0004, 4'b0001, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{"oe_ff",        32'h0700_0004, 4'h0, 32'h0, 32'h0000_00FF});
    vecs.push_back('{"w_oe_nostrb",  32'h0700_0004, 4'h0, 32'h0, 32'h0000_00FF});
    vecs.push_back('{"w_do_hi",      32'h0700_0000, 4'b1110, 32'hA5A5_A5A5, 32'h0});
    vecs.push_back('{"do_lane0_off", 32'h0700_0000, 4'h0, 32'h0, 32'h0});
    vecs.push_back('{"w_do",         32'h0700_0000, 4'hF, 32'h1234_565A, 32'h0});
    vecs.push_back('{"do_5a",        32'h0700_0000, 4'h0, 32'h0, 32'h0000_005A});
    vecs.push_back('{"w_pu",         32'h0700_000C, 4'hF, 32'h0000_FF3C, 32'h0});
    vecs.push_back('{"pu_3c",        32'h0700_000C, 4'h0, 32'h0, 32'h0000_003C});
    vecs.push_back('{"w_pd",         32'h0700_0010, 4'hF, 32'hC3, 32'h0});
    vecs.push_back('{"pd_c3",        32'h0700_0010, 4'h0, 32'h0, 32'h0000_00C3});
    vecs.push_back('{"w_din",        32'h0700_0008, 4'hF, 32'hFF, 32'h0});
    vecs.push_back('{"din_ro",       32'h0700_0008, 4'h0, 32'h0, 32'h0});
    vecs.push_back('{"w_unmapped",   32'h0700_0020, 4'hF, 32'hFF, 32'h0});
    vecs.push_back('{"rd_unmapped",  32'h0700_0020, 4'h0, 32'h0, 32'h0});
    vecs.push_back('{"alias_do",     32'h07AB_CD00, 4'h0, 32'h0, 32'h0000_005A});
    vecs.push_back('{"w_irq_en",     32'h0700_0014, 4'hF, 32'h08, 32'h0});
    vecs.push_back('{"irq_en_08",    32'h0700_0014, 4'h0, 32'h0, 32'h0000_0008});

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(iomem_ready), 32'd0);
    chk("rst_rdata", iomem_rdata, 32'h0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_out", 32'({gpio_out, gpio_oe, gpio_pullup, gpio_pulldown}), 32'h0);
    resetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      bus(vecs[i].addr, vecs[i].wstrb, vecs[i].wdata, r);
      if (vecs[i].wstrb == 4'h0) chk(vecs[i].name, r, vecs[i].exp);
    end
    chk("pin_out", 32'(gpio_out), 32'h5A);
    chk("pin_oe", 32'(gpio_oe), 32'hFF);
    chk("pin_pu", 32'(gpio_pullup), 32'h3C);
    chk("pin_pd", 32'(gpio_pulldown), 32'hC3);

    // Rising edge on channel 3: status sets SYNC_STAGES+1 (+debounce) edges
    // later and irq follows one edge after that.
    @(posedge clk); #1;
    gpio_in[3] = 1'b1;
    repeat (SYNC_STAGES + DB + 1) @(posedge clk);
    #1;
    chk("irq_before", 32'(irq), 32'd0);
    @(posedge clk); #1;
    chk("irq_rise", 32'(irq), 32'd1);
    rd_chk("status_b3", 32'h0700_0018, 32'h08);
    rd_chk("din_b3", 32'h0700_0008, 32'h08);
    wr(32'h0700_0018, 4'hF, 32'h08);
    @(posedge clk); #1;
    chk("irq_cleared", 32'(irq), 32'd0);
    rd_chk("status_clr", 32'h0700_0018, 32'h0);

    // Falling level does not set status; then a new rise lands on the same
    // edge as a W1C of that bit and must survive.
    gpio_in[3] = 1'b0;
    repeat (SYNC_STAGES + DB + 6) @(posedge clk);
    rd_chk("status_fall", 32'h0700_0018, 32'h0);
    @(posedge clk); #1;
    gpio_in[3] = 1'b1;
    repeat (SYNC_STAGES + DB) @(posedge clk);
    #1;
    iomem_valid = 1'b1; iomem_addr = 32'h0700_0018; iomem_wstrb = 4'hF; iomem_wdata = 32'h08;
    @(posedge clk); #1;
    chk("setwins_ready", 32'(iomem_ready), 32'd1);
    iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    rd_chk("status_setwins", 32'h0700_0018, 32'h08);
    @(posedge clk); #1;
    chk("irq_setwins", 32'(irq), 32'd1);

    // One-cycle glitch on channel 1: latched without debounce, filtered with.
    @(posedge clk); #1;
    gpio_in[1] = 1'b1;
    @(posedge clk); #1;
    gpio_in[1] = 1'b0;
    repeat (SYNC_STAGES + DB + 6) @(posedge clk);
`ifdef GPIO_DEBOUNCE_EN
    rd_chk("status_glitch", 32'h0700_0018, 32'h08);
`else
    rd_chk("status_glitch", 32'h0700_0018, 32'h0A);
`endif

    // Other base address: never acknowledged, DATA_OUT untouched.
    @(posedge clk); #1;
    iomem_valid = 1'b1; iomem_addr = 32'h0500_0000; iomem_wstrb = 4'hF; iomem_wdata = 32'h0;
    nsel_hits = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (iomem_ready) nsel_hits++;
    end
    iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    chk("nsel_ready", 32'(nsel_hits), 32'd0);
    rd_chk("nsel_do", 32'h0700_0000, 32'h5A);

    // Reset asserted during the ready cycle.
    gpio_in = '0;
    repeat (SYNC_STAGES + DB + 6) @(posedge clk);
    #1;
    iomem_valid = 1'b1; iomem_addr = 32'h0700_0000; iomem_wstrb = 4'h0;
    @(posedge clk); #1;
    chk("rr_ready", 32'(iomem_ready), 32'd1);
    chk("rr_rdata", iomem_rdata, 32'h5A);
    resetn = 1'b0;
    iomem_valid = 1'b0;
    @(posedge clk); #1;
    chk("rr_ready_after", 32'(iomem_ready), 32'd0);
    chk("rr_rdata_after", iomem_rdata, 32'h0);
    chk("rr_out", 32'({gpio_out, gpio_oe, gpio_pullup, gpio_pulldown}), 32'h0);
    chk("rr_irq", 32'(irq), 32'd0);
    resetn = 1'b1;
    rd_chk("rr_status", 32'h0700_0018, 32'h0);
    rd_chk("rr_irq_en", 32'h0700_0014, 32'h0);

`ifdef GPIO_DEBOUNCE_EN
    // 3-cycle pulse is filtered, exactly DEB_CYC cycles is accepted.
    @(posedge clk); #1;
    gpio_in[0] = 1'b1;
    repeat (DEB_CYC - 1) @(posedge clk);
    #1;
    gpio_in[0] = 1'b0;
    repeat (12) @(posedge clk);
    rd_chk("deb_short_din", 32'h0700_0008, 32'h0);
    rd_chk("deb_short_st", 32'h0700_0018, 32'h0);
    @(posedge clk); #1;
    gpio_in[0] = 1'b1;
    repeat (DEB_CYC) @(posedge clk);
    #1;
    gpio_in[0] = 1'b0;
    repeat (12) @(posedge clk);
    rd_chk("deb_exact_st", 32'h0700_0018, 32'h01);
    rd_chk("deb_exact_din", 32'h0700_0008, 32'h0);
    gpio_in[0] = 1'b1;
    repeat (12) @(posedge clk);
    rd_chk("deb_level_din", 32'h0700_0008, 32'h01);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
